fetch_ctrl: RTL
===============

# fetch_ctrl

Fetch-stage sequencer for the pipelined MIPS core. It owns the F-stage PC register and drives the instruction-memory request handshake. It also decides each next PC from three sources: sequential (+4), the D-stage NPC redirect, or a redirect target deferred while the delay-slot fetch is still outstanding. It sits between the hazard unit (stall), the D-stage NPC result, and the F/D pipeline register.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, PC of the first fetch after reset.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- stall  input  1  hazard-unit stall; 1 = F/D register holds.
- npc_redirect  input  1  D-stage branch taken or jump; meaningful only when stall=0.
- npc_target  input  32  D-stage computed target; valid with npc_redirect.
- im_req  output  1  instruction-memory request.
- im_addr  output  32  fetch address; always equals F_PC.
- im_ack  input  1  memory returns im_rdata this cycle; ignored when im_req=0.
- im_rdata  input  32  instruction word.
- F_PC  output  32  PC of the instruction being fetched or held.
- F_instr  output  32  instruction presented to the F/D register.
- F_valid  output  1  F_instr/F_PC are a real instruction; 0 = D receives a bubble.

## Operation
- States: REQ (waiting for memory) and HOLD (instruction buffered, D stalled).
- Internal registers:
  - F_PC.
  - state.
  - buf_instr (32).
  - pend (1) and pend_target (32): a redirect deferred until the delay slot is consumed.
- REQ outputs:
  - im_req=1.
  - F_valid=im_ack.
  - F_instr=im_rdata.
- HOLD outputs:
  - im_req=0.
  - F_valid=1.
  - F_instr=buf_instr.
- consume = F_valid & ~stall.
- Next PC on consume:
  - pend=1: pend_target, and pend clears.
  - else npc_redirect=1: npc_target.
  - else: F_PC+4, modulo 2^32 (wraps 0xFFFF_FFFC to 0x0000_0000).
- On consume, next state is REQ.
- REQ, im_ack=1, stall=1: buf_instr <= im_rdata, go HOLD, F_PC unchanged.
- REQ, im_ack=0, stall=0, npc_redirect=1: pend <= 1, pend_target <= npc_target.
  - This is a branch leaving D while its delay slot is still in flight.
- npc_redirect while pend=1 and no consume: ignored; the first pend_target is kept.
  - This cannot occur legally, because D holds a bubble.
- npc_redirect while stall=1: ignored in all states.
- HOLD with stall=1: all registers hold. im_ack in HOLD is ignored.
- Targets are used unmodified. No alignment check; low bits pass to im_addr as given.

## Timing
- Reset values (the cycle after reset is sampled low):
  - F_PC=RESET_PC.
  - state=REQ.
  - pend=0, pend_target=0, buf_instr=0.
  - Resulting outputs: im_req=1, im_addr=RESET_PC, F_valid=0 until the first im_ack.
- Reset mid-fetch: an outstanding request is abandoned, and a pending redirect or buffered instruction is discarded. An im_ack arriving in the first cycle after reset is accepted as the RESET_PC fetch.
- Zero-wait memory (im_ack in the same cycle as im_req) with stall=0 gives one instruction per cycle: F_PC advances every cycle.
- N-cycle memory: F_valid=0 for N-1 cycles, then 1 for exactly one cycle if stall=0.
- Redirect latency: a redirect consumed with the delay slot makes the next cycle's im_addr equal npc_target. A deferred redirect makes im_addr equal pend_target in the cycle after the delay slot is consumed.
- F_valid, F_instr and im_req are combinational from state and im_ack. All other outputs are registered.

## Test plan
- Reset, then zero-wait memory returning im_rdata=F_PC, stall=0:
  - Before reset release: im_addr=0x3000.
  - Afterwards: 0x3004, 0x3008 on consecutive cycles.
  - F_valid=1 every cycle.
- 3-cycle memory latency, stall=0:
  - F_valid pattern 0,0,1 repeating.
  - F_PC holds for 3 cycles per instruction.
- Stall during an ack:
  - im_ack with stall=1 for 2 cycles: HOLD, im_req=0, F_instr equals the buffered word.
  - Stall drops: consume, im_addr=old+4.
- Redirect with the delay slot present:
  - Sequence: F_PC=0x3010, im_ack=1, stall=0, npc_redirect=1, npc_target=0x3100.
  - Required: next im_addr=0x3100, not 0x3014.
- Deferred redirect:
  - Redirect to 0x3200 while REQ has no ack; then the ack for 0x3014 arrives with stall=0.
  - Required: F_valid=1 for 0x3014, then im_addr=0x3200, pend=0.
  - A second redirect during the wait does not change the target.
- Boundaries:
  - F_PC=0xFFFF_FFFC sequential consume gives 0x0000_0000.
  - Reset asserted while in HOLD with pend=1 gives im_addr=0x3000, pend=0, F_valid=0.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: hazard, D-stage redirect, instruction-memory and F/D signals of the fetch stage
interface fetch_ctrl_if;
    logic        stall;
    logic        npc_redirect;
    logic [31:0] npc_target;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;
    logic [31:0] F_PC;
    logic [31:0] F_instr;
    logic        F_valid;

    modport master (
        input  stall, npc_redirect, npc_target, im_ack, im_rdata,
        output im_req, im_addr, F_PC, F_instr, F_valid
    );

    modport slave (
        output stall, npc_redirect, npc_target, im_ack, im_rdata,
        input  im_req, im_addr, F_PC, F_instr, F_valid
    );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: F-stage PC sequencer with memory handshake, stall buffering and deferred redirects
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input logic          clk,
    input logic          reset,
    fetch_ctrl_if.master bus
);
    typedef enum logic {REQ, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic        pend_q, pend_d;
    logic [31:0] tgt_q, tgt_d;
    logic        valid;
    logic        consume;

    assign valid        = (state_q == REQ) ? bus.im_ack : 1'b1;
    assign consume      = valid & ~bus.stall;
    assign bus.im_req   = (state_q == REQ);
    assign bus.im_addr  = pc_q;
    assign bus.F_PC     = pc_q;
    assign bus.F_valid  = valid;
    assign bus.F_instr  = (state_q == REQ) ? bus.im_rdata : buf_q;

    // next PC selection, stall buffering and deferral of a redirect whose delay slot is still in flight
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        buf_d   = buf_q;
        pend_d  = pend_q;
        tgt_d   = tgt_q;
        if (consume) begin
            state_d = REQ;
            pend_d  = 1'b0;
            pc_d    = pend_q ? tgt_q : bus.npc_redirect ? bus.npc_target : pc_q + 32'd4;
        end else if (state_q == REQ && bus.im_ack && bus.stall) begin
            buf_d   = bus.im_rdata;
            state_d = HOLD;
        end else if (state_q == REQ && !bus.im_ack && !bus.stall && bus.npc_redirect && !pend_q) begin
            pend_d  = 1'b1;
            tgt_d   = bus.npc_target;
        end
    end

    // state registers; reset abandons any outstanding fetch, buffered word or pending redirect
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            buf_q   <= '0;
            pend_q  <= 1'b0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
            pend_q  <= pend_d;
            tgt_q   <= tgt_d;
        end
    end
endmodule
